// File: rtl/pkt_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : pkt_rr_arbiter_if
// Brief    : Upstream request bundle and downstream stream of the packet arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface pkt_rr_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_last;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      out_valid;
    logic [DATA_W-1:0]         out_data;
    logic                      out_last;
    logic [ID_W-1:0]           out_id;
    logic                      out_ready;

    // master is the arbiter side, slave is the surrounding environment
    modport master (
        input  req_valid, req_data, req_last, out_ready,
        output req_ready, out_valid, out_data, out_last, out_id
    );

    modport slave (
        output req_valid, req_data, req_last, out_ready,
        input  req_ready, out_valid, out_data, out_last, out_id
    );
endinterface
`default_nettype wire

// File: rtl/pkt_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : pkt_rr_arbiter
// Brief    : Per-packet round-robin arbiter with a registered output stage.
// Revision : 1.0 - initial release
// ============================================================================
module pkt_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    pkt_rr_arbiter_if.master bus
);
    localparam int              ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [ID_W-1:0] c_last_idx = ID_W'(NUM_REQ - 1);

    typedef enum logic [0:0] {
        ST_ARB  = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ID_W-1:0]     r_ptr;
    logic [ID_W-1:0]     w_ptr_nxt;
    logic [ID_W-1:0]     r_owner;
    logic [ID_W-1:0]     w_owner_nxt;

    logic                w_load;
    logic                w_hi_found;
    logic [ID_W-1:0]     w_hi_idx;
    logic [ID_W-1:0]     w_lo_idx;
    logic [ID_W-1:0]     w_winner;
    logic [ID_W-1:0]     w_sel;
    logic [ID_W-1:0]     w_sel_inc;
    logic                w_sel_valid;
    logic                w_sel_last;
    logic [DATA_W-1:0]   w_sel_data;
    logic                w_accept;
    logic [NUM_REQ-1:0]  w_ready;

    logic                r_out_valid;
    logic [DATA_W-1:0]   r_out_data;
    logic                r_out_last;
    logic [ID_W-1:0]     r_out_id;

    assign w_load = ~r_out_valid | bus.out_ready;

    // Rotating priority: the lowest valid index at or above ptr wins,
    // otherwise the lowest valid index overall (wrap-around).
    always_comb begin
        w_hi_found = 1'b0;
        w_hi_idx   = '0;
        w_lo_idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (bus.req_valid[i]) begin
                w_lo_idx = ID_W'(i);
                if (ID_W'(i) >= r_ptr) begin
                    w_hi_found = 1'b1;
                    w_hi_idx   = ID_W'(i);
                end
            end
        end
        w_winner = w_hi_found ? w_hi_idx : w_lo_idx;
    end

    assign w_sel = (r_state == ST_LOCK) ? r_owner : w_winner;

    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_last  = 1'b0;
        w_sel_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ID_W'(i) == w_sel) begin
                w_sel_valid = bus.req_valid[i];
                w_sel_last  = bus.req_last[i];
                w_sel_data  = bus.req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign w_accept  = w_sel_valid & w_load & ~rst;
    assign w_sel_inc = (w_sel == c_last_idx) ? '0 : w_sel + ID_W'(1);

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            w_ready[i] = w_accept && (ID_W'(i) == w_sel);
        end
    end

    assign bus.req_ready = w_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_owner_nxt = r_owner;
        if (w_accept) begin
            if (w_sel_last) begin
                w_ptr_nxt   = w_sel_inc;
                w_state_nxt = ST_ARB;
            end else begin
                w_owner_nxt = w_sel;
                w_state_nxt = ST_LOCK;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_ARB;
            r_ptr   <= '0;
            r_owner <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_owner <= w_owner_nxt;
        end
    end

    // Data fields only move on an accepted beat; a load without a beat just drops valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_out_id    <= '0;
        end else if (w_load) begin
            r_out_valid <= w_accept;
            if (w_accept) begin
                r_out_data <= w_sel_data;
                r_out_last <= w_sel_last;
                r_out_id   <= w_sel;
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_last  = r_out_last;
    assign bus.out_id    = r_out_id;

endmodule
`default_nettype wire

// File: tb/tb_pkt_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_pkt_rr_arbiter
// Brief    : Directed scoreboard bench for the round-robin packet arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pkt_rr_arbiter;
    localparam int NREQ = 4;
    localparam int DW   = 32;

    typedef struct packed {
        logic [3:0]    gap;
        logic          last;
        logic [DW-1:0] data;
    } beat_t;

    typedef struct packed {
        logic [1:0]    id;
        logic          last;
        logic [DW-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    pkt_rr_arbiter_if #(.NUM_REQ(NREQ), .DATA_W(DW)) bus ();

    pkt_rr_arbiter #(.NUM_REQ(NREQ), .DATA_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    beat_t src_q [NREQ][$];
    exp_t  exp_q [$];
    int    beat_cyc [$];
    int    n_vec = 0;
    int    n_err = 0;
    int    cyc   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic void send(input int r, input int gap, input logic last, input logic [DW-1:0] data);
        beat_t b;
        b.gap  = 4'(gap);
        b.last = last;
        b.data = data;
        src_q[r].push_back(b);
    endfunction

    function automatic void expect_beat(input int id, input logic last, input logic [DW-1:0] data);
        exp_t e;
        e.id   = 2'(id);
        e.last = last;
        e.data = data;
        exp_q.push_back(e);
    endfunction

    function automatic bit srcs_busy();
        bit b = 1'b0;
        for (int i = 0; i < NREQ; i++) if (src_q[i].size() != 0) b = 1'b1;
        return b;
    endfunction

    // Requester model: presents queue heads, honours per-beat idle gaps,
    // pops on handshake and abandons everything when reset rises.
    initial begin
        logic [NREQ-1:0] hs;
        int              gap_cnt [NREQ];
        bit              armed   [NREQ];
        logic            rst_prev;
        hs            = '0;
        rst_prev      = 1'b0;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_last  = '0;
        for (int i = 0; i < NREQ; i++) begin
            gap_cnt[i] = 0;
            armed[i]   = 1'b0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < NREQ; i++) begin
                if (rst && !rst_prev) begin
                    src_q[i].delete();
                    armed[i] = 1'b0;
                end else if (hs[i] && src_q[i].size() > 0) begin
                    void'(src_q[i].pop_front());
                    armed[i] = 1'b0;
                end
                if (src_q[i].size() > 0) begin
                    if (!armed[i]) begin
                        armed[i]   = 1'b1;
                        gap_cnt[i] = int'(src_q[i][0].gap);
                    end
                    if (gap_cnt[i] > 0) begin
                        gap_cnt[i]--;
                        bus.req_valid[i] = 1'b0;
                    end else begin
                        bus.req_valid[i]          = 1'b1;
                        bus.req_data[i*DW +: DW]  = src_q[i][0].data;
                        bus.req_last[i]           = src_q[i][0].last;
                    end
                end else begin
                    bus.req_valid[i] = 1'b0;
                end
            end
            rst_prev = rst;
            #4;
            hs = bus.req_valid & bus.req_ready;
        end
    end

    // Monitor: pops the scoreboard on every downstream transfer.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            #4;
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_beat: got id %0d data %h, required no beat", bus.out_id, bus.out_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_beat", 64'({bus.out_id, bus.out_last, bus.out_data}), 64'(e));
                end
                beat_cyc.push_back(cyc);
            end
        end
    end

    task automatic drain(input string name);
        int t = 0;
        while ((exp_q.size() != 0 || srcs_busy()) && t < 300) begin
            @(negedge clk);
            t++;
        end
        n_vec++;
        if (t >= 300) begin
            n_err++;
            $display("FAIL %s_drain: got %0d beats outstanding, required 0", name, exp_q.size());
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_out_valid(input string name);
        int t = 0;
        while (!bus.out_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        n_vec++;
        if (t >= 50) begin
            n_err++;
            $display("FAIL %s_wait: got out_valid 0, required 1 within 50 cycles", name);
        end
    endtask

    function automatic int gap_of(input int a, input int b);
        if (beat_cyc.size() <= b) return -1;
        return beat_cyc[b] - beat_cyc[a];
    endfunction

    initial begin
        int n0;
        bus.out_ready = 1'b1;

        // Reset state and first single-beat grant
        repeat (2) @(negedge clk);
        #1;
        send(1, 0, 1'b1, 32'hA5A5_0001);
        expect_beat(1, 1'b1, 32'hA5A5_0001);
        @(negedge clk);
        #2;
        chk("rst_req_ready", 64'(bus.req_ready), 64'h0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'h0);
        chk("rst_out_data",  64'(bus.out_data),  64'h0);
        chk("rst_out_last",  64'(bus.out_last),  64'h0);
        chk("rst_out_id",    64'(bus.out_id),    64'h0);
        rst = 1'b0;
        #1;
        chk("first_req_ready", 64'(bus.req_ready), 64'b0010);
        drain("single");

        // ptr is now 2: requesters 0 and 2 -> 2 first, then 0
        send(0, 0, 1'b1, 32'h0000_0B00);
        send(2, 0, 1'b1, 32'h0000_0B02);
        expect_beat(2, 1'b1, 32'h0000_0B02);
        expect_beat(0, 1'b1, 32'h0000_0B00);
        drain("ptr2");

        // ptr 1 -> single from 2 moves ptr to 3; then wrap 3 -> 0
        send(2, 0, 1'b1, 32'h0000_0C02);
        expect_beat(2, 1'b1, 32'h0000_0C02);
        drain("to_ptr3");
        send(0, 0, 1'b1, 32'h0000_0D00);
        send(3, 0, 1'b1, 32'h0000_0D03);
        expect_beat(3, 1'b1, 32'h0000_0D03);
        expect_beat(0, 1'b1, 32'h0000_0D00);
        drain("wrap");

        // ptr 1 -> single from 3 moves ptr to 0; then fairness
        send(3, 0, 1'b1, 32'h0000_0E03);
        expect_beat(3, 1'b1, 32'h0000_0E03);
        drain("to_ptr0");
        n0 = beat_cyc.size();
        for (int k = 0; k < 2; k++) begin
            for (int r = 0; r < NREQ; r++) begin
                send(r, 0, 1'b1, 32'hF000_0000 | 32'(k * 16 + r));
                expect_beat(r, 1'b1, 32'hF000_0000 | 32'(k * 16 + r));
            end
        end
        drain("fair");
        chk("fair_no_bubble", 64'(gap_of(n0, n0 + 7)), 64'd7);

        // ptr 0 -> single from 1 moves ptr to 2; then the packet lock
        send(1, 0, 1'b1, 32'h0000_1101);
        expect_beat(1, 1'b1, 32'h0000_1101);
        drain("to_ptr2");
        n0 = beat_cyc.size();
        send(2, 0, 1'b0, 32'h2222_0000);
        send(2, 0, 1'b0, 32'h2222_0001);
        send(2, 2, 1'b1, 32'h2222_0002);
        send(0, 0, 1'b1, 32'h3333_0000);
        send(1, 0, 1'b1, 32'h3333_0001);
        send(3, 0, 1'b1, 32'h3333_0003);
        expect_beat(2, 1'b0, 32'h2222_0000);
        expect_beat(2, 1'b0, 32'h2222_0001);
        expect_beat(2, 1'b1, 32'h2222_0002);
        expect_beat(3, 1'b1, 32'h3333_0003);
        expect_beat(0, 1'b1, 32'h3333_0000);
        expect_beat(1, 1'b1, 32'h3333_0001);
        drain("lock");
        chk("lock_b1_b2",   64'(gap_of(n0, n0 + 1)),     64'd1);
        chk("lock_idle2",   64'(gap_of(n0 + 1, n0 + 2)), 64'd3);
        chk("lock_handoff", 64'(gap_of(n0 + 2, n0 + 3)), 64'd1);

        // Back-pressure: ptr 2, only requester 0 active
        for (int k = 0; k < 3; k++) begin
            send(0, 0, 1'b1, 32'hB0B0_0000 | 32'(k));
            expect_beat(0, 1'b1, 32'hB0B0_0000 | 32'(k));
        end
        wait_out_valid("bp");
        bus.out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #3;
            chk("bp_req_ready", 64'(bus.req_ready), 64'h0);
            chk("bp_out_data",  64'(bus.out_data),  64'hB0B0_0000);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        drain("bp");

        // Reset mid-packet: requester 1, ptr 1
        bus.out_ready = 1'b0;
        send(1, 0, 1'b0, 32'hC1C1_0000);
        send(1, 0, 1'b0, 32'hC1C1_0001);
        send(1, 0, 1'b1, 32'hC1C1_0002);
        wait_out_valid("mid_rst");
        chk("mid_rst_beat1", 64'(bus.out_data), 64'hC1C1_0000);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", 64'(bus.out_valid), 64'h0);
        chk("mid_rst_out_data",  64'(bus.out_data),  64'h0);
        @(negedge clk);
        #1;
        send(0, 0, 1'b1, 32'hE0E0_0000);
        send(1, 0, 1'b1, 32'hE0E0_0001);
        expect_beat(0, 1'b1, 32'hE0E0_0000);
        expect_beat(1, 1'b1, 32'hE0E0_0001);
        bus.out_ready = 1'b1;
        @(negedge clk);
        #2;
        chk("mid_rst_req_ready_held", 64'(bus.req_ready), 64'h0);
        rst = 1'b0;
        #1;
        chk("post_rst_req_ready", 64'(bus.req_ready), 64'b0001);
        drain("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire

// File: doc/pkt_rr_arbiter.md
# pkt_rr_arbiter

Round-robin packet arbiter that shares one downstream valid/ready stream between `NUM_REQ` upstream requesters. It is the first synthesizable DUT for the UVM template bench: each requester port and the output port are driven or monitored by template agents. It arbitrates per packet, holding a grant from the first beat through the beat flagged `last`. Its output is registered, so it is fully pipelined at one beat per cycle.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters; legal range 1..16.
- `DATA_W`, default 32: beat payload width.
- `ID_W`, default `$clog2(NUM_REQ)` with a minimum of 1: width of the requester index. Derived; not overridden.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  NUM_REQ  per-requester beat valid.
- `req_data`  in  NUM_REQ*DATA_W  per-requester payload; requester i occupies bits [i*DATA_W +: DATA_W].
- `req_last`  in  NUM_REQ  per-requester end-of-packet flag.
- `req_ready`  out  NUM_REQ  per-requester accept; at most one bit set in any cycle.
- `out_valid`  out  1  registered output beat valid.
- `out_data`  out  DATA_W  registered payload.
- `out_last`  out  1  registered end-of-packet flag.
- `out_id`  out  ID_W  index of the requester that sourced the beat.
- `out_ready`  in  1  downstream accept.

## Operation
- Handshakes:
  - Upstream beat transfer: `req_valid[i] & req_ready[i]`.
  - Downstream beat transfer: `out_valid & out_ready`.
  - Requesters hold `req_valid`, `req_data` and `req_last` stable until accepted.
- Load enable: `load = ~out_valid | out_ready`. The output register accepts a new beat only when `load` is 1.
- State machine, 2 states:
  - ARB:
    - The winner is the first i with `req_valid[i]=1`, scanning from `ptr` upward and wrapping from `NUM_REQ-1` to 0.
    - `req_ready[winner] = load`.
    - On an accepted beat with `req_last=0`: set `owner = winner` and go to LOCK.
    - On an accepted beat with `req_last=1`: stay in ARB and set `ptr = (winner+1) mod NUM_REQ`.
  - LOCK:
    - Only `owner` is eligible: `req_ready[owner] = load & req_valid[owner]`. All other `req_ready` bits are 0.
    - If the owner drops `req_valid` between beats, the arbiter waits; it never re-arbitrates mid-packet.
    - On an accepted owner beat with `req_last=1`: set `ptr = (owner+1) mod NUM_REQ` and return to ARB.
- Output register on an accepted beat: `out_valid<=1`, and `out_data`, `out_last`, `out_id` take the accepted beat's fields.
- Output register when `load=1` and no beat is accepted: `out_valid<=0`. Data fields hold their previous values.
- `ptr` changes only on packet completion. A single-beat packet is a packet with `last=1` on its first beat.
- `NUM_REQ=1`: `ptr` is constantly 0, `out_id` is constantly 0, and the FSM still tracks packets.
- Reset (asynchronous, at any time, including mid-packet):
  - Outputs: `out_valid=0`, `out_data=0`, `out_last=0`, `out_id=0`.
  - State: FSM to ARB, `ptr=0`, `owner=0`.
  - A partially transferred packet is abandoned; no recovery.
  - `req_ready` is combinational and is 0 while `rst` is high.

## Timing
- Latency: an upstream beat accepted in cycle N appears on `out_*` in cycle N+1.
- Throughput: 1 beat per cycle while `out_ready=1` and the eligible requester is valid.
- `req_ready` is combinational from `req_valid`, `out_valid`, `out_ready`, FSM state and `ptr`. There is no combinational path from `req_data` to any output.
- A downstream stall (`out_ready=0` with `out_valid=1`) forces all `req_ready` bits to 0 in the same cycle.
- Simultaneous events:
  - A downstream accept and an upstream accept in the same cycle replace the output beat back-to-back; there is no bubble.
  - The last beat of one packet and the first beat of the next packet (from the new `ptr`) transfer in consecutive cycles.

## Test plan
- Reset then single requester: `req_valid=4'b0010`, data `0xA5A5_0001`, `last=1`, `out_ready=1` -> `req_ready=4'b0010` in cycle 0; cycle 1 shows `out_valid=1`, `out_id=1`, `out_data=0xA5A5_0001`; afterwards `ptr=2`.
- Fairness: all 4 requesters continuously valid with single-beat packets, `out_ready=1` -> `out_id` sequence 0,1,2,3,0,1,… with no bubbles; 8 beats complete in 9 cycles.
- Packet lock: requester 2 sends a 3-beat packet (`last` only on beat 3) while requesters 0, 1 and 3 are all valid -> three consecutive `out_id=2` beats, then `out_id=3`; requester 2 dropping `req_valid` for 2 cycles mid-packet inserts 2 idle cycles and no other ID.
- Back-pressure: hold `out_ready=0` for 5 cycles with `out_valid=1` -> all `req_ready` are 0, `out_data` is stable, and no beat is lost or duplicated after release.
- Wrap-around: `ptr=3` with requesters 0 and 3 valid -> 3 is granted, then 0.
- Reset mid-packet: assert `rst` after beat 1 of a 3-beat packet from requester 1 -> `out_valid=0` immediately; after release, requester 0 wins (`ptr=0`, FSM in ARB).
